// File: rtl/pwl_pkg.sv
// Shared definitions for the pseudo-softmax PWL datapath.
//   DW        : default score / reciprocal / output width
//   N_DEFAULT : default number of scores per frame
//   state_t   : normaliser sequencing states
//   sat_shift : shift a 2*DW-bit product right and clamp it to DW bits
package pwl_pkg;

   localparam int DW        = 8;
   localparam int N_DEFAULT = 4;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      WAIT = 2'd1,
      EMIT = 2'd2
   } state_t;

   function automatic logic [DW-1:0] sat_shift(input logic [2*DW-1:0] product,
                                               input int unsigned     shift);
      logic [2*DW-1:0] v;
      v = product >> shift;
      if (|v[2*DW-1:DW]) begin
         return {DW{1'b1}};
      end
      return v[DW-1:0];
   endfunction

endpackage

// File: rtl/softmax_normalizer_norm_mul.sv
// Registered DW x DW unsigned multiply, right shift by SHIFT, saturate to DW.
// One cycle of latency; the output register only loads when i_en is high so
// the result holds while the consumer stalls.
//   clk, rst_n : clock, synchronous active-low reset (clears o_y)
//   i_en       : load a new result
//   i_a, i_b   : operands
//   o_y        : sat_DW((i_a * i_b) >> SHIFT)
module norm_mul import pwl_pkg::*; #(
   parameter int DW    = pwl_pkg::DW,
   parameter int SHIFT = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_en,
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   output logic [DW-1:0] o_y
);

   logic [2*DW-1:0] w_prod;
   logic [DW-1:0]   w_sat;
   logic [DW-1:0]   r_y;

   assign w_prod = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};

   // The shared helper is fixed to the package width; other widths use the
   // same clamp written out locally.
   generate
      if (DW == pwl_pkg::DW) begin : g_pkg
         assign w_sat = sat_shift(w_prod, unsigned'(SHIFT));
      end else begin : g_gen
         logic [2*DW-1:0] w_shr;
         assign w_shr = w_prod >> SHIFT;
         assign w_sat = (|w_shr[2*DW-1:DW]) ? {DW{1'b1}} : w_shr[DW-1:0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_y <= '0;
      end else if (i_en) begin
         r_y <= w_sat;
      end
   end

   assign o_y = r_y;

endmodule

// File: rtl/softmax_normalizer.sv
// Normalisation stage of the pseudo-softmax datapath. Buffers a frame of N
// scores, presents their mean to the reciprocal stage, latches the returned
// reciprocal and streams score*reciprocal (shifted, saturated) downstream.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_data    : score input, accepted when in_ready (LOAD only)
//   in_ready            : stage accepts a score
//   sum_out             : frame mean, drives the reciprocal stage
//   recip_in            : reciprocal of sum_out, valid RECIP_LAT cycles later
//   out_valid/out_data  : normalised score with valid/ready handshake
//   out_last            : marks the N-th output of a frame
//   out_ready           : consumer accepts output
//
// state | meaning
// LOAD  | accepting scores into the buffer, accumulating the sum
// WAIT  | mean presented, waiting RECIP_LAT cycles for the reciprocal
// EMIT  | streaming buffered scores times the latched reciprocal
module softmax_normalizer import pwl_pkg::*; #(
   parameter int N         = pwl_pkg::N_DEFAULT,
   parameter int DW        = pwl_pkg::DW,
   parameter int RECIP_LAT = 1,
   parameter int OUT_SHIFT = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic [DW-1:0] sum_out,
   input  logic [DW-1:0] recip_in,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   input  logic          out_ready
);

   localparam int LGN = $clog2(N);
   localparam int SW  = DW + LGN;
   localparam int WCW = (RECIP_LAT < 1) ? 1 : $clog2(RECIP_LAT + 1);
   localparam logic [LGN-1:0] LAST_IDX  = LGN'(N - 1);
   localparam logic [WCW-1:0] WAIT_LOAD = WCW'(RECIP_LAT);

   state_t         r_state;
   state_t         w_next;
   logic [DW-1:0]  r_buf [N];
   logic [LGN-1:0] r_idx;
   logic [SW-1:0]  r_sum;
   logic [SW-1:0]  w_new_sum;
   logic [DW-1:0]  r_sum_out;
   logic [DW-1:0]  r_recip_q;
   logic [WCW-1:0] r_wait_cnt;
   logic           r_all_issued;
   logic           r_out_valid;
   logic           r_out_last;
   logic           w_in_ready;
   logic           w_in_fire;
   logic           w_out_fire;
   logic           w_advance;
   logic           w_issue;

   assign w_in_fire  = in_valid && w_in_ready;
   assign w_new_sum  = r_sum + SW'(in_data);
   assign w_out_fire = r_out_valid && out_ready;
   // The output register may take a new value when empty or being drained.
   assign w_advance  = !r_out_valid || out_ready;
   assign w_issue    = (r_state == EMIT) && w_advance && !r_all_issued;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= LOAD;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         LOAD: if (w_in_fire && (r_idx == LAST_IDX)) w_next = WAIT;
         WAIT: if (r_wait_cnt == '0) w_next = EMIT;
         EMIT: if (w_out_fire && r_out_last) w_next = LOAD;
         default: w_next = LOAD;
      endcase
   end

   always_comb begin
      w_in_ready = (r_state == LOAD);
   end

   // Buffer holds data only; a reset discards it by clearing the index.
   always_ff @(posedge clk) begin
      if (rst_n && w_in_fire) begin
         r_buf[r_idx] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx        <= '0;
         r_sum        <= '0;
         r_sum_out    <= '0;
         r_recip_q    <= '0;
         r_wait_cnt   <= WAIT_LOAD;
         r_all_issued <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
      end else begin
         case (r_state)
            LOAD: begin
               if (w_in_fire) begin
                  if (r_idx == LAST_IDX) begin
                     r_idx      <= '0;
                     r_sum      <= '0;
                     r_sum_out  <= w_new_sum[SW-1:LGN];
                     r_wait_cnt <= WAIT_LOAD;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                     r_sum <= w_new_sum;
                  end
               end
            end
            WAIT: begin
               if (r_wait_cnt == '0) begin
                  r_recip_q <= recip_in;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 1'b1;
               end
            end
            EMIT: begin
               if (w_issue) begin
                  r_out_valid <= 1'b1;
                  r_out_last  <= (r_idx == LAST_IDX);
                  r_idx       <= r_idx + 1'b1;
                  if (r_idx == LAST_IDX) r_all_issued <= 1'b1;
               end else if (w_out_fire) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
               end
               if (w_out_fire && r_out_last) r_all_issued <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   norm_mul #(
      .DW    (DW),
      .SHIFT (OUT_SHIFT)
   ) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_issue),
      .i_a   (r_buf[r_idx]),
      .i_b   (r_recip_q),
      .o_y   (out_data)
   );

   assign in_ready  = w_in_ready;
   assign sum_out   = r_sum_out;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;

endmodule
